// File: rtl/partita_driver_if.sv
// rtl/partita_driver_if.sv - engine-side handshake between the game driver and the game FSMD.
interface partita_driver_if;
  logic       inizia;
  logic [1:0] primo;
  logic [1:0] secondo;
  logic [1:0] manche;
  logic [1:0] partita;

  modport master (output inizia, primo, secondo, input manche, partita);
  modport slave  (input inizia, primo, secondo, output manche, partita);
endinterface

// File: rtl/partita_driver.sv
// rtl/partita_driver.sv - autonomous two-player stimulus driver with LFSR move generators.
// Optional macro LEGAL_MOVES_EN enables move legalization against each player's last winning move.
module partita_driver #(
  parameter int MAX_MOVES = 16,
  parameter int LFSR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        cfg_a,
  input  logic [1:0]        cfg_b,
  input  logic [LFSR_W-1:0] seed,
  partita_driver_if.master  eng,
  output logic              busy,
  output logic              done,
  output logic [1:0]        result,
  output logic              timeout,
  output logic [3:0]        wins1,
  output logic [3:0]        wins2,
  output logic [3:0]        ties
);

  localparam int CW = $clog2(MAX_MOVES + 1);
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(8'h71);

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_SETTLE, S_PLAY, S_WAIT, S_DONE} state_t;

  state_t            state, state_n;
  logic [LFSR_W-1:0] l1, l2, seed_inv;
  logic [1:0]        cfg_a_q, cfg_b_q;
  logic [1:0]        f1, f2, m1, m2, m1_q, m2_q;
  logic [CW-1:0]     cnt;
  logic              inizia_c;
  logic [1:0]        primo_c, secondo_c;
  logic              accept;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], 1'b0} ^ (v[LFSR_W-1] ? TAPS : '0);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

`ifdef LEGAL_MOVES_EN
  function automatic logic [1:0] legalize(input logic [1:0] raw, input logic [1:0] f);
    logic [1:0] base;
    base = (raw == 2'b00) ? 2'b01 : raw;
    if (f != 2'b00 && base == f)
      return (base == 2'b11) ? 2'b01 : base + 2'b01;
    return base;
  endfunction

  assign m1 = legalize(l1[1:0], f1);
  assign m2 = legalize(l2[1:0], f2);
`else
  assign m1 = l1[1:0];
  assign m2 = l2[1:0];
`endif

  assign seed_inv = ~seed;
  assign accept   = start && (state == S_IDLE || state == S_DONE);

  always_comb begin
    state_n   = state;
    inizia_c  = 1'b0;
    primo_c   = 2'b00;
    secondo_c = 2'b00;
    case (state)
      S_IDLE:   if (start) state_n = S_CFG;
      S_CFG: begin
        inizia_c  = 1'b1;
        primo_c   = cfg_a_q;
        secondo_c = cfg_b_q;
        state_n   = S_SETTLE;
      end
      S_SETTLE: state_n = S_PLAY;
      S_PLAY: begin
        primo_c   = m1;
        secondo_c = m2;
        state_n   = (eng.partita != 2'b00) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (eng.partita != 2'b00 || cnt == CW'(MAX_MOVES)) state_n = S_DONE;
        else                                               state_n = S_PLAY;
      end
      S_DONE:   if (start) state_n = S_CFG;
      default:  state_n = S_IDLE;
    endcase
  end

  assign eng.inizia  = inizia_c;
  assign eng.primo   = primo_c;
  assign eng.secondo = secondo_c;
  assign busy        = (state == S_CFG) || (state == S_SETTLE) || (state == S_PLAY) || (state == S_WAIT);
  assign done        = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      l1      <= '0;
      l2      <= '0;
      cfg_a_q <= 2'b00;
      cfg_b_q <= 2'b00;
      f1      <= 2'b00;
      f2      <= 2'b00;
      m1_q    <= 2'b00;
      m2_q    <= 2'b00;
      cnt     <= '0;
      wins1   <= 4'd0;
      wins2   <= 4'd0;
      ties    <= 4'd0;
      result  <= 2'b00;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        // An all-zero LFSR would lock up, so either generator starting at zero gets 1 instead.
        l1      <= (seed == '0) ? LFSR_W'(1) : seed;
        l2      <= (seed_inv == '0) ? LFSR_W'(1) : seed_inv;
        cfg_a_q <= cfg_a;
        cfg_b_q <= cfg_b;
        cnt     <= '0;
        wins1   <= 4'd0;
        wins2   <= 4'd0;
        ties    <= 4'd0;
        result  <= 2'b00;
        timeout <= 1'b0;
      end
      if (state == S_PLAY) begin
        l1   <= lfsr_next(l1);
        l2   <= lfsr_next(l2);
        m1_q <= m1;
        m2_q <= m2;
        cnt  <= cnt + CW'(1);
        if (eng.partita != 2'b00) result <= eng.partita;
      end
      if (state == S_WAIT) begin
        case (eng.manche)
          2'b01: begin wins1 <= sat_inc(wins1); f1 <= m1_q;  f2 <= 2'b00; end
          2'b10: begin wins2 <= sat_inc(wins2); f2 <= m2_q;  f1 <= 2'b00; end
          2'b11: begin ties  <= sat_inc(ties);  f1 <= 2'b00; f2 <= 2'b00; end
          default: ;
        endcase
        // An engine verdict outranks the watchdog when both land in the same cycle.
        if (eng.partita != 2'b00) begin
          result <= eng.partita;
        end else if (cnt == CW'(MAX_MOVES)) begin
          result  <= 2'b11;
          timeout <= 1'b1;
        end
      end
    end
  end

endmodule
